// File: rtl/path_delay_pkg.sv
// Shared definitions for the path delay sequencer: FSM encoding and selector width helper.
package path_delay_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_REPORT,
    ST_RECOVER
  } state_e;

  // Selector width for n chains; a single chain still gets a 1-bit index.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/path_delay_sequencer_capture_sync.sv
// Single-bit multi-flop synchroniser for one asynchronous chain output.
module capture_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= '0;
    else        ff_q <= {ff_q[STAGES-2:0], d};
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/path_delay_sequencer.sv
// Launches a rising edge into one delay chain, counts clock cycles until the
// synchronised chain output flips, and hands the count out over valid/ready.
module path_delay_sequencer
  import path_delay_pkg::*;
#(
  parameter int unsigned          NUM_PATHS     = 4,
  parameter int unsigned          CNT_W         = 16,
  parameter int unsigned          SYNC_STAGES   = 2,
  parameter int unsigned          SETTLE_CYCLES = 8,
  parameter logic [NUM_PATHS-1:0] POLARITY      = '0,
  localparam int unsigned         SEL_W         = sel_width(NUM_PATHS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SEL_W-1:0]     path_sel,
  input  logic [CNT_W-1:0]     timeout,
  output logic                 busy,
  output logic [NUM_PATHS-1:0] launch,
  input  logic [NUM_PATHS-1:0] capture,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [SEL_W-1:0]     res_path,
  output logic [CNT_W-1:0]     res_cycles,
  output logic                 res_timeout
);

  localparam int unsigned    SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W:0]   PATHS_EXT   = (SEL_W+1)'(NUM_PATHS);

  state_e               state_q, state_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     limit_q, limit_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NUM_PATHS-1:0] launch_d;
  logic                 busy_d;
  logic                 res_valid_d;
  logic [SEL_W-1:0]     res_path_d;
  logic [CNT_W-1:0]     res_cycles_d;
  logic                 res_timeout_d;

  logic [NUM_PATHS-1:0] sync_out;
  logic                 sel_oob;
  logic                 hit;

  for (genvar i = 0; i < NUM_PATHS; i++) begin : g_sync
    capture_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (capture[i]),
      .q     (sync_out[i])
    );
  end

  assign sel_oob = {1'b0, path_sel} >= PATHS_EXT;
  // Chain has reached its settled level once output differs from its polarity bit.
  assign hit     = sync_out[sel_q] ^ POLARITY[sel_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      settle_q    <= '0;
      cnt_q       <= '0;
      limit_q     <= '0;
      sel_q       <= '0;
      launch      <= '0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_path    <= '0;
      res_cycles  <= '0;
      res_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      cnt_q       <= cnt_d;
      limit_q     <= limit_d;
      sel_q       <= sel_d;
      launch      <= launch_d;
      busy        <= busy_d;
      res_valid   <= res_valid_d;
      res_path    <= res_path_d;
      res_cycles  <= res_cycles_d;
      res_timeout <= res_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    settle_d      = settle_q;
    cnt_d         = cnt_q;
    limit_d       = limit_q;
    sel_d         = sel_q;
    launch_d      = launch;
    busy_d        = busy;
    res_valid_d   = res_valid;
    res_path_d    = res_path;
    res_cycles_d  = res_cycles;
    res_timeout_d = res_timeout;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d    = path_sel;
          limit_d  = (timeout == '0) ? '1 : timeout;
          settle_d = '0;
          busy_d   = 1'b1;
          if (sel_oob) begin
            state_d       = ST_REPORT;
            res_valid_d   = 1'b1;
            res_path_d    = path_sel;
            res_cycles_d  = '0;
            res_timeout_d = 1'b1;
          end else begin
            state_d = ST_SETTLE;
          end
        end
      end

      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = ST_MEASURE;
          cnt_d    = '0;
          launch_d = NUM_PATHS'(1) << sel_q;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end

      // Capture is tested before the limit so a simultaneous match is reported as a measurement.
      ST_MEASURE: begin
        if (hit) begin
          state_d       = ST_REPORT;
          res_valid_d   = 1'b1;
          res_path_d    = sel_q;
          res_cycles_d  = cnt_q;
          res_timeout_d = 1'b0;
        end else if (cnt_q == limit_q - CNT_W'(1)) begin
          state_d       = ST_REPORT;
          res_valid_d   = 1'b1;
          res_path_d    = sel_q;
          res_cycles_d  = limit_q;
          res_timeout_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_REPORT: begin
        if (res_ready) begin
          state_d     = ST_RECOVER;
          res_valid_d = 1'b0;
          launch_d    = '0;
          settle_d    = '0;
        end
      end

      ST_RECOVER: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
